// File: rtl/demux_sched_pkg.sv
// Shared constants, FSM state type and channel helpers for the round-robin demux scheduler.
package demux_sched_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] sel);
        ch_onehot      = '0;
        ch_onehot[sel] = 1'b1;
    endfunction

endpackage

// File: rtl/demux_rr_pick.sv
// Combinational round-robin search: first enabled channel after i_grant, wrapping back to i_grant.
module demux_rr_pick
    import demux_sched_pkg::*;
(
    input  logic [CH_W-1:0]   i_grant,
    input  logic [NUM_CH-1:0] i_en,
    output logic [CH_W-1:0]   o_next,
    output logic              o_any
);

    logic [CH_W-1:0] w_idx;
    logic            w_found;

    // The last candidate (k = NUM_CH) wraps to i_grant itself, so a lone enabled channel picks itself.
    always_comb begin
        o_next  = i_grant;
        w_found = 1'b0;
        w_idx   = i_grant;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_idx = i_grant + CH_W'(k);
            if (!w_found && i_en[w_idx]) begin
                o_next  = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign o_any = |i_en;

endmodule

// File: rtl/demux_rr_scheduler.sv
// One-entry buffered 1-to-4 demux; accepted words are steered to channels in round-robin bursts.
// Handshake: a transfer happens on a channel in any cycle where its valid and ready are both high.
module demux_rr_scheduler
    import demux_sched_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int BURST  = 4,
    localparam int CNT_W  = $clog2(BURST + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NUM_CH-1:0] cfg_en,
    output logic [DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [CH_W-1:0]   grant,
    output logic              busy,
    output logic              dbg_state,
    output logic [CNT_W-1:0]  dbg_beat_cnt
);

    state_t            r_state;
    state_t            w_next_state;
    logic [DATA_W-1:0] r_buf_data;
    logic [CH_W-1:0]   r_buf_sel;
    logic [CH_W-1:0]   r_grant;
    logic [CNT_W-1:0]  r_beat_cnt;

    logic [CH_W-1:0]   w_grant_next;
    logic [CH_W-1:0]   w_target;
    logic [CH_W-1:0]   w_target_next;
    logic [CNT_W-1:0]  w_beat_inc;
    logic              w_any_en;
    logic              w_any_unused;
    logic              w_buf_vld;
    logic              w_xfer_in;
    logic              w_xfer_out;
    logic              w_burst_done;

    demux_rr_pick u_pick_grant (
        .i_grant (r_grant),
        .i_en    (cfg_en),
        .o_next  (w_grant_next),
        .o_any   (w_any_en)
    );

    demux_rr_pick u_pick_target (
        .i_grant (w_target),
        .i_en    (cfg_en),
        .o_next  (w_target_next),
        .o_any   (w_any_unused)
    );

    assign w_buf_vld  = (r_state == HOLD);
    assign w_xfer_out = w_buf_vld && out_ready[r_buf_sel];
    assign w_xfer_in  = in_valid && in_ready;

    // A disabled grant pointer is skipped forward to the next enabled channel for this beat.
    assign w_target     = cfg_en[r_grant] ? r_grant : w_grant_next;
    assign w_beat_inc   = (w_target != r_grant) ? CNT_W'(1) : (r_beat_cnt + CNT_W'(1));
    assign w_burst_done = (w_beat_inc == CNT_W'(BURST));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            EMPTY: if (w_xfer_in) w_next_state = HOLD;
            HOLD:  if (w_xfer_out && !w_xfer_in) w_next_state = EMPTY;
            default: w_next_state = EMPTY;
        endcase
    end

    // Outputs are forced idle during the reset cycle, before the registers have been cleared.
    always_comb begin
        in_ready  = !rst && (!w_buf_vld || out_ready[r_buf_sel]) && w_any_en;
        busy      = !rst && w_buf_vld;
        out_valid = (!rst && w_buf_vld) ? ch_onehot(r_buf_sel) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_data <= '0;
            r_buf_sel  <= '0;
            r_grant    <= '0;
            r_beat_cnt <= '0;
        end else if (w_xfer_in) begin
            r_buf_data <= in_data;
            r_buf_sel  <= w_target;
            if (w_burst_done) begin
                r_grant    <= w_target_next;
                r_beat_cnt <= '0;
            end else begin
                r_grant    <= w_target;
                r_beat_cnt <= w_beat_inc;
            end
        end
    end

    assign out_data     = r_buf_data;
    assign grant        = r_grant;
    assign dbg_state    = r_state;
    assign dbg_beat_cnt = r_beat_cnt;

endmodule

// File: doc/demux_rr_scheduler.md
DEMUX_RR_SCHEDULER -- requirements
Module: demux_rr_scheduler

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits.
REQ-002 Parameter BURST, default 4, beats granted to one channel before rotation; legal range 1..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_data  input  DATA_W  upstream payload.
REQ-006 in_valid  input  1  upstream word present.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 cfg_en  input  4  per-channel enable mask; bit i enables channel i.
REQ-009 out_data  output  DATA_W  payload shared by all four channels.
REQ-010 out_valid  output  4  one-hot channel strobe; bit i means the word targets channel i.
REQ-011 out_ready  input  4  per-channel downstream ready.
REQ-012 grant  output  2  current round-robin channel pointer.
REQ-013 busy  output  1  high while a word is buffered.

Function
REQ-014 Transfer in: occurs when in_valid and in_ready are both high in the same cycle.
REQ-015 Transfer out: occurs when out_valid[i] and out_ready[i] are both high in the same cycle.
REQ-016 Buffering: one-entry output register (buf_data, buf_sel, buf_vld); out_data = buf_data.
REQ-017 out_valid = onehot(buf_sel) when buf_vld, else 4'b0000.
REQ-018 in_ready = (!buf_vld || out_ready[buf_sel]) && (cfg_en != 0).
REQ-019 Pipelining: latency is exactly one cycle from transfer in to out_valid; full throughput with simultaneous transfer in and out.
REQ-020 FSM: two states, EMPTY (buf_vld=0) and HOLD (buf_vld=1).
REQ-021 EMPTY -> HOLD on transfer in.
REQ-022 HOLD -> EMPTY on transfer out without transfer in.
REQ-023 HOLD stays HOLD on transfer out with simultaneous transfer in, or when there is no transfer out.
REQ-024 Target channel for transfer in: T = grant if cfg_en[grant], else rr_next(grant).
REQ-025 rr_next(g) is the first enabled channel searching g+1, g+2, g+3, g mod 4 (wrap 3->0).
REQ-026 On transfer in: buf_sel <= T.
REQ-027 On transfer in, beat counter: if T != grant, beat_cnt restarts at 1; otherwise beat_cnt increments.
REQ-028 Rotation: when the accepted beat is the BURST-th beat for T, grant <= rr_next(T) and beat_cnt <= 0; otherwise grant <= T.
REQ-029 BURST=1 rotates on every beat.
REQ-030 Every enabled channel is granted within 3 bursts (starvation bound).
REQ-031 A buffered word keeps buf_sel after cfg_en changes and is delivered normally.
REQ-032 With cfg_en = 0: no transfer in; grant and beat_cnt hold; a buffered word still drains.
REQ-033 While HOLD without transfer out: out_valid and out_data are held stable.
REQ-034 beat_cnt width is clog2(BURST+1); it never exceeds BURST.

Reset
REQ-035 On rst: buf_vld=0, buf_data=0, buf_sel=0, grant=0, beat_cnt=0, FSM=EMPTY.
REQ-036 Outputs during rst: out_valid=0000, busy=0.
REQ-037 Reset mid-transfer discards the buffered word without a transfer out.
REQ-038 in_ready is low during the rst cycle.

Structure
REQ-039 Shared package demux_sched_pkg holds the constant NUM_CH=4 and the FSM state typedef (EMPTY, HOLD).
REQ-040 One combinational sub-module, demux_rr_pick, computes rr_next(g, cfg_en) and an any-enabled flag.
REQ-041 All other logic resides in demux_rr_scheduler.

Verification
REQ-042 Reset scenario: rst high 2 cycles with a word buffered -> out_valid=0000, busy=0, grant=0 after release.
REQ-043 Round-robin scenario: cfg_en=1111, out_ready=1111, stream 0x01..0x10 back-to-back.
 - 0x01-0x04 go to ch0, 0x05-0x08 to ch1, 0x09-0x0C to ch2, 0x0D-0x10 to ch3.
 - One-cycle latency, no bubbles.
REQ-044 Sparse-mask scenario: cfg_en=0101, stream 0x01..0x08 -> 0x01-0x04 on ch0, 0x05-0x08 on ch2, grant ends at 0.
REQ-045 Backpressure scenario: 0xAA buffered for ch0 with out_ready[0]=0 for 5 cycles.
 - out_valid=0001 and out_data=0xAA stable, in_ready=0 throughout.
 - Raising out_ready[0] completes the transfer in one cycle.
REQ-046 Mid-burst disable scenario: cfg_en=1111, 2 beats sent to ch1, then cfg_en=1101.
 - Next beat goes to ch2 with beat_cnt=1; ch2 then receives 4 beats.
REQ-047 Empty-mask scenario: cfg_en=0000 with 0x55 buffered for ch3.
 - 0x55 is delivered, in_ready stays 0, no further out_valid.
